reg_cmd_bridge: RTL and testbench

REG_CMD_BRIDGE -- requirements
Module: reg_cmd_bridge

---
 rtl/reg_cmd_bridge.sv | 158 +++++++++++++++
 tb/tb_reg_cmd_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_bridge.sv
// reg_cmd_bridge: turns a host byte stream into register-file reads and writes.
// Command layout: header {dir, addr[6:0]}, length L, then L+1 payload bytes.
// Writes go straight through to the register file on the byte's transfer edge.
// Reads capture reg_rdata one location at a time and stream it back on tx.
module reg_cmd_bridge #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [6:0] reg_num,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RLOAD = 3'd3;
  localparam logic [2:0] S_RSEND = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  remaining_q, remaining_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        timeout_q, timeout_d;

  logic rx_fire;
  logic tx_fire;
  logic rx_phase;
  logic idle_hit;

  // Host-facing handshakes; rx is refused during the abort pulse so a byte
  // arriving right as a command is dropped cannot be mistaken for a header.
  always_comb begin
    rx_ready = ((state_q == S_IDLE) || (state_q == S_LEN) || (state_q == S_WDATA))
               && !timeout_q;
    rx_fire  = rx_valid && rx_ready;
    tx_fire  = tx_valid_q && tx_ready;
    rx_phase = (state_q == S_LEN) || (state_q == S_WDATA);
    idle_hit = rx_phase && !rx_fire && (idle_cnt_q == (TIMEOUT_CYCLES - 16'd1));
  end

  // Register-file side: address is always the running addr, write is a
  // combinational strobe so data lands on the same edge it is accepted.
  always_comb begin
    reg_num   = addr_q;
    reg_wdata = rx_data;
    reg_wr    = (state_q == S_WDATA) && rx_fire;
    tx_data   = tx_data_q;
    tx_valid  = tx_valid_q;
    timeout   = timeout_q;
  end

  // Command parser next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    is_wr_d     = is_wr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          addr_d  = rx_data[6:0];
          is_wr_d = rx_data[7];
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_fire) begin
          remaining_d = rx_data;
          state_d     = is_wr_q ? S_WDATA : S_RLOAD;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          if (remaining_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            remaining_d = remaining_q - 8'd1;
            addr_d      = addr_q + 7'd1;
          end
        end
      end
      S_RLOAD: begin
        // reg_num has been addr for this whole cycle, so reg_rdata is settled.
        tx_data_d  = reg_rdata;
        tx_valid_d = 1'b1;
        state_d    = S_RSEND;
      end
      S_RSEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (remaining_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            remaining_d = remaining_q - 8'd1;
            addr_d      = addr_q + 7'd1;
            state_d     = S_RLOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Host went quiet mid-command: abandon it. Bytes already written stay.
    if (idle_hit) begin
      state_d   = S_IDLE;
      timeout_d = 1'b1;
    end
  end

  // Idle-gap counter only runs while waiting for command bytes; any transfer,
  // any other state, or the abort itself (entry to IDLE) returns it to zero.
  always_comb begin
    idle_cnt_d = 16'd0;
    if (rx_phase && !rx_fire && !idle_hit)
      idle_cnt_d = idle_cnt_q + 16'd1;
  end

  // State registers, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 7'd0;
      remaining_q <= 8'd0;
      is_wr_q     <= 1'b0;
      idle_cnt_q  <= 16'd0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      is_wr_q     <= is_wr_d;
      idle_cnt_q  <= idle_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Scoreboard bench for reg_cmd_bridge with a behavioural 128x8 register file.
module tb_reg_cmd_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [6:0] reg_num;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       timeout;

  reg_cmd_bridge #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_num(reg_num), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // register file the bridge drives
  logic [7:0] rf [0:127];
  always @(posedge clk) if (reg_wr) rf[reg_num] <= reg_wdata;
  assign reg_rdata = rf[reg_num];

  int n_chk = 0;
  int n_pass = 0;
  int n_wr = 0;
  int n_to = 0;
  logic [14:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  shadow [0:127];
  logic [14:0] wr_e;
  logic [7:0]  tx_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
  endtask

  task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    shadow[a] = d;
  endtask

  // drive one byte, return after its transfer edge (+1); waits = refused cycles
  task automatic send_byte(input logic [7:0] b, output int waits);
    rx_data = b; rx_valid = 1'b1; waits = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) begin @(posedge clk); #1; break; end
      waits++;
      if (waits > 50) begin chk("rx_stall", 0, 1); @(posedge clk); #1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // output monitor: write strobes, tx transfers, timeout pulses
  always @(negedge clk) begin
    if (reg_wr) begin
      if (wr_q.size() == 0) chk("wr_extra", {reg_num, reg_wdata}, 15'h7fff);
      else begin
        wr_e = wr_q.pop_front();
        chk("wr_num", reg_num, wr_e[14:8]);
        chk("wr_data", reg_wdata, wr_e[7:0]);
      end
      n_wr++;
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_extra", tx_data, 9'h1ff);
      else begin
        tx_e = tx_q.pop_front();
        chk("tx_data", tx_data, tx_e);
      end
    end
    if (timeout) n_to++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang exp finish");
    $fatal(1);
  end

  initial begin
    int w, ws, wr0;
    logic bad;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_rdy", rx_ready, 1);
    chk("rst_wr", reg_wr, 0);
    chk("rst_num", reg_num, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_to", timeout, 0);
    @(posedge clk); #1 reset = 1'b1;
    cycles(2);

    // single write, valid held
    wr0 = n_wr; ws = 0;
    exp_wr(7'd5, 8'hAB);
    send_byte(8'h85, w); ws += w;
    send_byte(8'h00, w); ws += w;
    send_byte(8'hAB, w); ws += w;
    rx_valid = 1'b0;
    cycles(2);
    chk("w1_rdy", ws, 0);
    chk("w1_cnt", n_wr - wr0, 1);

    // fill 5..7, then read them back at one byte per two cycles
    send_byte(8'h85, w); send_byte(8'h02, w);
    exp_wr(7'd5, 8'h11); send_byte(8'h11, w);
    exp_wr(7'd6, 8'h22); send_byte(8'h22, w);
    exp_wr(7'd7, 8'h33); send_byte(8'h33, w);
    rx_valid = 1'b0;
    cycles(2);
    tx_q.push_back(shadow[5]); tx_q.push_back(shadow[6]); tx_q.push_back(shadow[7]);
    send_byte(8'h05, w); send_byte(8'h02, w);
    rx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_gap", tx_valid, 0);
      chk("rd_rdy", rx_ready, 0);
      @(negedge clk);
      chk("rd_vld", tx_valid, 1);
      chk("rd_num", reg_num, 5 + k);
    end
    @(negedge clk);
    chk("rd_idle", rx_ready, 1);
    chk("rd_done", tx_valid, 0);
    cycles(1);

    // address wrap 127 -> 0
    send_byte(8'hFF, w); send_byte(8'h01, w);
    exp_wr(7'd127, 8'h01); send_byte(8'h01, w);
    exp_wr(7'd0, 8'h02);   send_byte(8'h02, w);
    rx_valid = 1'b0;
    cycles(2);

    // read held off by tx_ready=0 for 20 cycles
    send_byte(8'hA0, w); send_byte(8'h00, w);
    exp_wr(7'h20, 8'h5A); send_byte(8'h5A, w);
    rx_valid = 1'b0;
    cycles(1);
    tx_ready = 1'b0;
    send_byte(8'h20, w); send_byte(8'h00, w);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("bp_load", tx_valid, 0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== shadow[7'h20] || rx_ready || timeout || reg_num !== 7'h20)
        bad = 1'b1;
    end
    chk("bp_hold", bad, 0);
    tx_q.push_back(shadow[7'h20]);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_take", tx_valid, 1);
    @(negedge clk);
    chk("bp_drop", tx_valid, 0);
    chk("bp_idle", rx_ready, 1);
    cycles(1);

    // timeout after a lone header; byte in the pulse cycle is refused
    send_byte(8'h85, w);
    rx_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (timeout) bad = 1'b1;
    end
    chk("to_early", bad, 0);
    @(posedge clk); #1;
    chk("to_pulse", timeout, 1);
    chk("to_rdy", rx_ready, 0);
    tx_q.push_back(shadow[5]);
    send_byte(8'h05, w);
    chk("to_drop", w, 1);
    send_byte(8'h00, w);
    rx_valid = 1'b0;
    cycles(5);
    chk("to_rd", tx_q.size(), 0);

    // reset in the middle of a 4-byte write
    send_byte(8'h90, w); send_byte(8'h03, w);
    exp_wr(7'h10, 8'hD0); send_byte(8'hD0, w);
    exp_wr(7'h11, 8'hD1); send_byte(8'hD1, w);
    rx_data = 8'hD2;
    reset = 1'b0;
    rx_valid = 1'b0;
    wr0 = n_wr;
    @(negedge clk);
    chk("mr_rdy", rx_ready, 1);
    chk("mr_wr", reg_wr, 0);
    chk("mr_num", reg_num, 0);
    chk("mr_txv", tx_valid, 0);
    chk("mr_txd", tx_data, 8'h00);
    chk("mr_to", timeout, 0);
    @(posedge clk); #1 reset = 1'b1;
    cycles(10);
    chk("mr_nowr", n_wr - wr0, 0);
    exp_wr(7'd3, 8'h77);
    send_byte(8'h83, w); send_byte(8'h00, w); send_byte(8'h77, w);
    rx_valid = 1'b0;
    cycles(3);
    chk("mr_wr1", n_wr - wr0, 1);

    chk("wr_left", wr_q.size(), 0);
    chk("tx_left", tx_q.size(), 0);
    chk("to_count", n_to, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
